// File: rtl/multiword_add_sequencer.sv
// multiword_add_sequencer
// Sequential front/back-end for an external N_BIT combinational adder.
// One wide addition of N_WORDS*N_BIT bits is performed as N_WORDS passes
// through the adder, least-significant word first. Each pass's carry_out
// is chained into the next pass's carry_in. The sum words, final carry and
// top-word signed overflow are collected into registered outputs.
//
// Optional feature: define MULTIWORD_SUB_EN to add a 'sub' input. When
// sub=1 at start, B is latched inverted and the word-0 carry is forced to 1,
// so result = A - B. In that mode, carry_out=1 means no borrow occurred.

module multiword_add_sequencer #(
    parameter int N_BIT   = 32,
    parameter int N_WORDS = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
`ifdef MULTIWORD_SUB_EN
    input  logic                       sub,
`endif
    input  logic [N_BIT*N_WORDS-1:0]   operand_a,
    input  logic [N_BIT*N_WORDS-1:0]   operand_b,
    input  logic                       carry_in,
    output logic [N_BIT-1:0]           add_operand_1,
    output logic [N_BIT-1:0]           add_operand_2,
    output logic                       add_carry_in,
    input  logic [N_BIT-1:0]           add_sum,
    input  logic                       add_carry_out,
    input  logic                       add_overflow,
    output logic [N_BIT*N_WORDS-1:0]   result,
    output logic                       carry_out,
    output logic                       overflow,
    output logic                       busy,
    output logic                       done
);

    // Index width: clog2(N_WORDS), never narrower than one bit.
    localparam int IW = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(N_WORDS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]                 state;
    logic [IW-1:0]              word_idx;
    logic                       carry_q;
    logic                       cin_q;
    logic [N_BIT*N_WORDS-1:0]   op_a_q;
    logic [N_BIT*N_WORDS-1:0]   op_b_q;

    // Values captured at an accepted start; subtraction folds into the
    // latched operands so the RUN datapath is identical for add and sub.
    logic [N_BIT*N_WORDS-1:0]   op_b_next;
    logic                       cin_next;

`ifdef MULTIWORD_SUB_EN
    // Select the B word and word-0 carry to latch for add or subtract.
    always_comb begin
        op_b_next = sub ? ~operand_b : operand_b;
        cin_next  = sub ? 1'b1 : carry_in;
    end
`else
    // Add-only build: latch B and carry_in unchanged.
    always_comb begin
        op_b_next = operand_b;
        cin_next  = carry_in;
    end
`endif

    // Status outputs decode directly from the state register.
    always_comb begin
        busy = (state == S_RUN) || (state == S_DONE);
        done = (state == S_DONE);
    end

    // Drive the external adder with the current word; idle outputs are zero.
    always_comb begin
        add_operand_1 = '0;
        add_operand_2 = '0;
        add_carry_in  = 1'b0;
        if (state == S_RUN) begin
            for (int unsigned w = 0; w < N_WORDS; w++) begin
                if (word_idx == IW'(w)) begin
                    add_operand_1 = op_a_q[w*N_BIT +: N_BIT];
                    add_operand_2 = op_b_q[w*N_BIT +: N_BIT];
                end
            end
            add_carry_in = (word_idx == '0) ? cin_q : carry_q;
        end
    end

    // Sequencer state, operand latches, carry chain and result collection.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            word_idx  <= '0;
            carry_q   <= 1'b0;
            cin_q     <= 1'b0;
            op_a_q    <= '0;
            op_b_q    <= '0;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_a_q    <= operand_a;
                        op_b_q    <= op_b_next;
                        cin_q     <= cin_next;
                        word_idx  <= '0;
                        carry_q   <= 1'b0;
                        result    <= '0;
                        carry_out <= 1'b0;
                        overflow  <= 1'b0;
                        state     <= S_RUN;
                    end
                end
                S_RUN: begin
                    for (int unsigned w = 0; w < N_WORDS; w++) begin
                        if (word_idx == IW'(w)) begin
                            result[w*N_BIT +: N_BIT] <= add_sum;
                        end
                    end
                    carry_q <= add_carry_out;
                    if (word_idx == LAST_IDX) begin
                        // Only the top word's overflow is meaningful.
                        carry_out <= add_carry_out;
                        overflow  <= add_overflow;
                        state     <= S_DONE;
                    end else begin
                        word_idx <= word_idx + 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Directed self-checking bench for multiword_add_sequencer (N_BIT=8,
// N_WORDS=4) with a behavioural 8-bit adder closing the loop.
module tb_multiword_add_sequencer;

    localparam int NB = 8;
    localparam int NW = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
`ifdef MULTIWORD_SUB_EN
    logic              sub;
`endif
    logic [NB*NW-1:0]  operand_a;
    logic [NB*NW-1:0]  operand_b;
    logic              carry_in;
    logic [NB-1:0]     add_operand_1;
    logic [NB-1:0]     add_operand_2;
    logic              add_carry_in;
    logic [NB-1:0]     add_sum;
    logic              add_carry_out;
    logic              add_overflow;
    logic [NB*NW-1:0]  result;
    logic              carry_out;
    logic              overflow;
    logic              busy;
    logic              done;

    int checks = 0;
    int errors = 0;

    multiword_add_sequencer #(.N_BIT(NB), .N_WORDS(NW)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
`ifdef MULTIWORD_SUB_EN
        .sub           (sub),
`endif
        .operand_a     (operand_a),
        .operand_b     (operand_b),
        .carry_in      (carry_in),
        .add_operand_1 (add_operand_1),
        .add_operand_2 (add_operand_2),
        .add_carry_in  (add_carry_in),
        .add_sum       (add_sum),
        .add_carry_out (add_carry_out),
        .add_overflow  (add_overflow),
        .result        (result),
        .carry_out     (carry_out),
        .overflow      (overflow),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    // External reference adder: sum, carry and signed overflow.
    always_comb begin
        {add_carry_out, add_sum} = {1'b0, add_operand_1} + {1'b0, add_operand_2}
                                   + {{NB{1'b0}}, add_carry_in};
        add_overflow = (add_operand_1[NB-1] == add_operand_2[NB-1]) &&
                       (add_sum[NB-1] != add_operand_1[NB-1]);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Start one op from IDLE, wait (bounded) for done, check latency and results.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic ci, input logic [31:0] er, input logic ec,
                          input logic eo);
        int n;
        @(negedge clk);
        operand_a = a; operand_b = b; carry_in = ci; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'd5);
        chk({tag, "_result"}, result, er);
        chk({tag, "_carry"}, 32'(carry_out), 32'(ec));
        chk({tag, "_ovf"}, 32'(overflow), 32'(eo));
    endtask

    initial begin
        int n;
        rst = 1'b1; start = 1'b0; operand_a = '0; operand_b = '0; carry_in = 1'b0;
`ifdef MULTIWORD_SUB_EN
        sub = 1'b0;
`endif
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset / idle state
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", result, 32'h0);
        chk("rst_carry", 32'(carry_out), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("idle_op1", 32'(add_operand_1), 32'd0);
        chk("idle_cin", 32'(add_carry_in), 32'd0);

        // Carry ripple across words: 0x00FFFFFF + 1, carry chain 0,1,1,1
        operand_a = 32'h00FFFFFF; operand_b = 32'h00000001; carry_in = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_op1_w0", 32'(add_operand_1), 32'hFF);
        chk("t1_op2_w0", 32'(add_operand_2), 32'h01);
        chk("t1_cin0", 32'(add_carry_in), 32'd0);
        @(negedge clk);
        chk("t1_cin1", 32'(add_carry_in), 32'd1);
        @(negedge clk);
        chk("t1_cin2", 32'(add_carry_in), 32'd1);
        @(negedge clk);
        chk("t1_op1_w3", 32'(add_operand_1), 32'h00);
        chk("t1_cin3", 32'(add_carry_in), 32'd1);
        chk("t1_nodone", 32'(done), 32'd0);
        @(negedge clk);
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_result", result, 32'h01000000);
        chk("t1_carry", 32'(carry_out), 32'd0);
        chk("t1_ovf", 32'(overflow), 32'd0);
        @(negedge clk);
        chk("t1_done_pulse", 32'(done), 32'd0);
        chk("t1_idle_busy", 32'(busy), 32'd0);
        chk("t1_hold", result, 32'h01000000);

        // All-ones plus carry_in wraps to zero with carry out
        run_op("t2", 32'hFFFFFFFF, 32'h0, 1'b1, 32'h00000000, 1'b1, 1'b0);
        // Signed overflow on the top word
        run_op("t3", 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1);

        // start held high with operands changing every cycle
        @(negedge clk);
        operand_a = 32'h11223344; operand_b = 32'h01010101; carry_in = 1'b0; start = 1'b1;
        @(negedge clk);
        n = 1;
        while (!done && n < 20) begin
            operand_a = 32'hFFFF0000 ^ 32'(n * 32'h01234567);
            operand_b = 32'h80808080 + 32'(n);
            carry_in  = ~carry_in;
            @(negedge clk);
            n++;
        end
        chk("t4_latency", 32'(n), 32'd5);
        chk("t4_result", result, 32'h12233445);
        chk("t4_carry", 32'(carry_out), 32'd0);
        operand_a = 32'h00000010; operand_b = 32'h00000020; carry_in = 1'b0;
        @(negedge clk);
        chk("t4_gap_busy", 32'(busy), 32'd0);
        chk("t4_gap_hold", result, 32'h12233445);
        @(negedge clk);
        start = 1'b0;
        chk("t4_second_busy", 32'(busy), 32'd1);
        n = 1;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t4_second_latency", 32'(n), 32'd5);
        chk("t4_second_result", result, 32'h00000030);

        // Reset while processing word index 2
        @(negedge clk);
        operand_a = 32'h01020304; operand_b = 32'h01010101; carry_in = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_done", 32'(done), 32'd0);
        chk("t5_result", result, 32'h0);
        @(negedge clk);
        chk("t5_no_done", 32'(done), 32'd0);
        run_op("t5_after", 32'h3, 32'h4, 1'b0, 32'h7, 1'b0, 1'b0);

`ifdef MULTIWORD_SUB_EN
        // Subtraction: carry_out=1 means no borrow
        sub = 1'b1;
        run_op("sub_neg", 32'h5, 32'h7, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b0);
        run_op("sub_pos", 32'h7, 32'h5, 1'b0, 32'h00000002, 1'b1, 1'b0);
        sub = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multiword_add_sequencer.md
Name: multiword_add_sequencer

Overview:
- Sequential front/back-end for the N_BIT combinational adder (carry-select or ripple-carry).
- Performs one wide addition of N_WORDS*N_BIT bits in N_WORDS consecutive passes through the single external adder.
- Feeds the adder one operand word per cycle, chaining carry_out of each pass into the carry_in of the next.
- Collects the sum words, final carry and final signed overflow into a registered wide result.

Parameters:
- N_BIT, 32, width of the external adder and of one word
- N_WORDS, 4, number of words per wide operand (>=2)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- start  in  1  request a new addition; sampled only in IDLE
- operand_a  in  N_BIT*N_WORDS  wide operand A
- operand_b  in  N_BIT*N_WORDS  wide operand B
- carry_in  in  1  carry into word 0
- add_operand_1  out  N_BIT  word of A to adder
- add_operand_2  out  N_BIT  word of B to adder
- add_carry_in  out  1  carry to adder
- add_sum  in  N_BIT  adder sum (combinational, same cycle)
- add_carry_out  in  1  adder carry out
- add_overflow  in  1  adder signed overflow
- result  out  N_BIT*N_WORDS  wide sum, registered
- carry_out  out  1  final carry, registered
- overflow  out  1  signed overflow of top word, registered
- busy  out  1  high in RUN and DONE
- done  out  1  one-cycle pulse, result valid

Behaviour:
- Interface: one clock (clk); reset synchronous, active-high (rst).
- Reset: state=IDLE; result=0, carry_out=0, overflow=0, busy=0, done=0; word index=0; internal carry=0; latched operands=0.
- States: IDLE, RUN, DONE.
- IDLE -> RUN on start=1:
  - latch operand_a, operand_b, carry_in
  - index<=0
  - clear result, carry_out, overflow
- RUN, each cycle:
  - add_operand_1/2 = latched word[index], bits index*N_BIT +: N_BIT.
  - add_carry_in = latched carry_in when index==0, else internal carry register.
  - On clock edge: result word[index]<=add_sum; internal carry<=add_carry_out; index<=index+1.
  - At index==N_WORDS-1: also carry_out<=add_carry_out, overflow<=add_overflow; go to DONE.
- DONE: done=1 for exactly this one cycle, busy=1; next state IDLE.
- Outside RUN: add_operand_1/2 = 0, add_carry_in = 0.
- Latency: start sampled at edge k; done high during cycle k+N_WORDS+1, i.e. the N_WORDS+1th cycle after start.
- Back-to-back: start is honoured in the first IDLE cycle after DONE, so throughput is one op per N_WORDS+2 cycles.
- start while busy (RUN or DONE): ignored; not queued.
- Changing operand_a/b/carry_in after start: no effect on the current operation (latched).
- result/carry_out/overflow hold their values from DONE until the next accepted start, which clears them.
- rst mid-operation: abort and apply reset values next cycle; done is not asserted for the aborted operation.
- Overflow reflects the top word only; lower-word overflow flags are ignored.
- Index counter width: clog2(N_WORDS), minimum 1 bit; it never wraps past N_WORDS-1.

Optional Feature:
- Macro: MULTIWORD_SUB_EN.
- Defined:
  - Extra input port sub (1 bit), latched at start together with the operands.
  - When sub=1: latched B is stored bitwise inverted and the word-0 carry is forced to 1, ignoring carry_in, so result = A-B.
  - Borrow convention: carry_out=1 means no borrow.
- Undefined: port absent; add only.

Test Plan (N_BIT=8, N_WORDS=4, adder = reference carry-select model):
- A=0x00FFFFFF, B=0x00000001, cin=0, start -> done 5 cycles later; result=0x01000000, carry_out=0, overflow=0; add_carry_in sequence 0,1,1,1.
- A=0xFFFFFFFF, B=0, cin=1 -> result=0x00000000, carry_out=1, overflow=0.
- A=0x7FFFFFFF, B=0x00000001, cin=0 -> result=0x80000000, carry_out=0, overflow=1.
- start held high continuously with new operands each cycle -> second op begins only the cycle after done; the first result is unaffected by operand changes mid-op.
- rst asserted at RUN index 2 -> next cycle: IDLE, busy=0, result=0, no done pulse; a following start with A=3, B=4 gives result=7.
- (MULTIWORD_SUB_EN) A=5, B=7, sub=1 -> result=0xFFFFFFFE, carry_out=0; A=7, B=5, sub=1 -> result=2, carry_out=1.
